// File: rtl/display_spi_scheduler_pkg.sv
// Shared display SPI definitions: frame layout, display register map and FSM state codes.
package display_spi_scheduler_pkg;

  localparam logic [3:0] CMD_WRITE    = 4'b0001;
  localparam int         FRAME_BITS   = 16;
  localparam int         DEF_NUM_REGS = 10;
  localparam logic [3:0] ENABLE_REG   = 4'd0;
  localparam logic [3:0] RADIX_REG    = 4'd9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_LOW0 = 3'd2;
  localparam logic [2:0] ST_HIGH = 3'd3;
  localparam logic [2:0] ST_LOW  = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0] addr,
                                                       input logic [7:0] data);
    return {CMD_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/display_spi_scheduler_spi_frame_tx.sv
// spi_frame_tx: 16-bit MSB-first SPI serializer with SCLK divider and trailing SS-high gap.
module spi_frame_tx
  import display_spi_scheduler_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  idle,
  output logic                  done,
  output logic                  sclk,
  output logic                  ss,
  output logic                  mosi
);

  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HP_LAST   = HW'(HALF_PERIOD - 1);
  localparam logic [HW-1:0] LOW0_LAST = HW'((HALF_PERIOD > 1) ? HALF_PERIOD - 2 : 0);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 2);

  logic [2:0]            state_reg;
  logic [HW-1:0]         hcnt_reg;
  logic [GW-1:0]         gcnt_reg;
  logic [4:0]            bcnt_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  sclk_reg, ss_reg, mosi_reg, done_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      hcnt_reg  <= '0;
      gcnt_reg  <= '0;
      bcnt_reg  <= '0;
      shift_reg <= '0;
      sclk_reg  <= 1'b0;
      ss_reg    <= 1'b1;
      mosi_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: if (start) begin
          state_reg <= ST_LOAD;
          shift_reg <= frame;
          bcnt_reg  <= '0;
          ss_reg    <= 1'b0;
          mosi_reg  <= frame[FRAME_BITS-1];
        end
        ST_LOAD: begin
          if (HALF_PERIOD > 1) begin
            state_reg <= ST_LOW0;
            hcnt_reg  <= LOW0_LAST;
          end else begin
            state_reg <= ST_HIGH;
            sclk_reg  <= 1'b1;
            hcnt_reg  <= HP_LAST;
          end
        end
        ST_LOW0: begin
          if (hcnt_reg != '0) hcnt_reg <= hcnt_reg - 1'b1;
          else begin
            state_reg <= ST_HIGH;
            sclk_reg  <= 1'b1;
            hcnt_reg  <= HP_LAST;
          end
        end
        ST_HIGH: begin
          if (hcnt_reg != '0) hcnt_reg <= hcnt_reg - 1'b1;
          else begin
            // Ones are shifted in behind the data, so after bit 0 mosi settles high for the last LOW.
            state_reg <= ST_LOW;
            sclk_reg  <= 1'b0;
            hcnt_reg  <= HP_LAST;
            bcnt_reg  <= bcnt_reg + 1'b1;
            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b1};
            mosi_reg  <= shift_reg[FRAME_BITS-2];
          end
        end
        ST_LOW: begin
          if (hcnt_reg != '0) hcnt_reg <= hcnt_reg - 1'b1;
          else if (bcnt_reg == 5'(FRAME_BITS)) begin
            state_reg <= ST_GAP;
            ss_reg    <= 1'b1;
            done_reg  <= 1'b1;
            gcnt_reg  <= GAP_LAST;
          end else begin
            state_reg <= ST_HIGH;
            sclk_reg  <= 1'b1;
            hcnt_reg  <= HP_LAST;
          end
        end
        ST_GAP: begin
          if (gcnt_reg != '0) gcnt_reg <= gcnt_reg - 1'b1;
          else state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign idle = (state_reg == ST_IDLE);
  assign done = done_reg;
  assign sclk = sclk_reg;
  assign ss   = ss_reg;
  assign mosi = mosi_reg;

endmodule

// File: rtl/display_spi_scheduler.sv
// Two-port round-robin write scheduler for the display SPI slave.
// Optional shadow register file (skips redundant writes) enabled by DISP_SCHED_SHADOW_EN.
module display_spi_scheduler
  import display_spi_scheduler_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int NUM_REGS    = DEF_NUM_REGS
) (
  input  logic       block_clk_i,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic [3:0] req0_addr_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [3:0] req1_addr_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       spi_sclk_o,
  output logic       spi_ss_o,
  output logic       spi_mosi_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       grant_o
);

  logic       grant_reg, drop_reg, err_reg;
  logic       tx_idle, tx_done;
  logic       sel, accept, addr_ok, hit, send;
  logic [3:0] addr;
  logic [7:0] data;

  // With both ports valid the port that did not win last time is served.
  always_comb begin
    sel    = (req0_valid_i && req1_valid_i) ? ~grant_reg : req1_valid_i;
    addr   = sel ? req1_addr_i : req0_addr_i;
    data   = sel ? req1_data_i : req0_data_i;
    accept = tx_idle && (sel ? req1_valid_i : req0_valid_i);
  end

  assign req0_ready_o = tx_idle && !sel;
  assign req1_ready_o = tx_idle && sel;
  assign addr_ok      = int'(addr) < NUM_REGS;
  assign send         = accept && addr_ok && !hit;

`ifdef DISP_SCHED_SHADOW_EN
  logic [7:0]          shadow_mem [NUM_REGS];
  logic [NUM_REGS-1:0] shadow_valid_reg;

  assign hit = addr_ok && shadow_valid_reg[addr] && (shadow_mem[addr] == data);

  always_ff @(posedge block_clk_i) begin
    if (rst_i) shadow_valid_reg <= '0;
    else if (send) shadow_valid_reg[addr] <= 1'b1;
  end

  always_ff @(posedge block_clk_i) begin
    if (send) shadow_mem[addr] <= data;
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      grant_reg <= 1'b1;
      drop_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      drop_reg <= accept && !send;
      err_reg  <= accept && !addr_ok;
      if (accept) grant_reg <= sel;
    end
  end

  spi_frame_tx #(
    .HALF_PERIOD(HALF_PERIOD),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_tx (
    .clk  (block_clk_i),
    .srst (rst_i),
    .start(send),
    .frame(make_frame(addr, data)),
    .idle (tx_idle),
    .done (tx_done),
    .sclk (spi_sclk_o),
    .ss   (spi_ss_o),
    .mosi (spi_mosi_o)
  );

  assign busy_o  = !tx_idle;
  assign done_o  = tx_done | drop_reg;
  assign err_o   = err_reg;
  assign grant_o = grant_reg;

endmodule

// File: tb/tb_display_spi_scheduler.sv
// Bench for display_spi_scheduler: two instances (HALF_PERIOD 2/GAP 4 and 1/2) checked each cycle
// against a transaction-level timing model plus an SPI pin monitor that reassembles frames.
module tb_display_spi_scheduler;

  logic       clk, rst;
  logic       v0 [2], v1 [2];
  logic [3:0] a0 [2], a1 [2];
  logic [7:0] d0 [2], d1 [2];
  logic       r0 [2], r1 [2], sclk [2], ss [2], mosi [2];
  logic       busy [2], done [2], err [2], grant [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // model state
  int          bcnt [2];
  bit          g [2], drop_pend [2], err_pend [2], acc [2], exp_pending [2];
  bit          obs_done [2], obs_err [2];
  logic [15:0] exp_frame [2], bits [2], last_frame [2];
  // pin monitor state
  bit          ss_prev [2], sclk_prev [2], mosi_prev [2];
  int          low_len [2], high_len [2], edges [2], mosi_run [2];
`ifdef DISP_SCHED_SHADOW_EN
  logic [7:0]  sh [2][10];
  bit          shv [2][10];
`endif

  typedef struct {
    bit          port;
    logic [3:0]  addr;
    logic [7:0]  data;
    bit          exp_err;
    logic [15:0] frame;
  } vec_t;
  vec_t vecs [7];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      display_spi_scheduler #(
        .HALF_PERIOD(gi == 0 ? 2 : 1),
        .GAP_CYCLES (gi == 0 ? 4 : 2),
        .NUM_REGS   (10)
      ) dut (
        .block_clk_i (clk),
        .rst_i       (rst),
        .req0_valid_i(v0[gi]),
        .req0_addr_i (a0[gi]),
        .req0_data_i (d0[gi]),
        .req0_ready_o(r0[gi]),
        .req1_valid_i(v1[gi]),
        .req1_addr_i (a1[gi]),
        .req1_data_i (d1[gi]),
        .req1_ready_o(r1[gi]),
        .spi_sclk_o  (sclk[gi]),
        .spi_ss_o    (ss[gi]),
        .spi_mosi_o  (mosi[gi]),
        .busy_o      (busy[gi]),
        .done_o      (done[gi]),
        .err_o       (err[gi]),
        .grant_o     (grant[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic reset_model(input int i);
    bcnt[i] = 0; g[i] = 1'b1; drop_pend[i] = 0; err_pend[i] = 0; acc[i] = 0;
    exp_pending[i] = 0; ss_prev[i] = 1; sclk_prev[i] = 0; mosi_prev[i] = 1;
    low_len[i] = 0; high_len[i] = 1000; edges[i] = 0; mosi_run[i] = 0; bits[i] = '0;
`ifdef DISP_SCHED_SHADOW_EN
    for (int k = 0; k < 10; k++) shv[i][k] = 0;
`endif
  endtask

  // One clock: check outputs at the falling edge, advance the model, return 1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int hp, gp;
      bit idle, sel, vs;
      logic [3:0] a;
      logic [7:0] d;
      hp   = (i == 0) ? 2 : 1;
      gp   = (i == 0) ? 4 : 2;
      idle = (bcnt[i] == 0);
      sel  = (v0[i] && v1[i]) ? !g[i] : v1[i];
      vs   = sel ? v1[i] : v0[i];
      a    = sel ? a1[i] : a0[i];
      d    = sel ? d1[i] : d0[i];
      obs_done[i] = done[i];
      obs_err[i]  = err[i];
      if (chk_en) begin
        chk("ready0", i, int'(r0[i]), int'(idle && !sel));
        chk("ready1", i, int'(r1[i]), int'(idle && sel));
        chk("busy",   i, int'(busy[i]), int'(!idle));
        chk("done",   i, int'(done[i]), int'(drop_pend[i] || (bcnt[i] == gp - 1)));
        chk("err",    i, int'(err[i]), int'(err_pend[i]));
        chk("grant",  i, int'(grant[i]), int'(g[i]));
        mosi_run[i] = (mosi[i] == mosi_prev[i]) ? mosi_run[i] + 1 : 1;
        if (!ss[i]) begin
          if (ss_prev[i]) begin
            chk("gap_len_ok", i, int'(high_len[i] >= gp), 1);
            low_len[i] = 0; edges[i] = 0; bits[i] = '0;
          end
          low_len[i]++;
          if (sclk[i] && !sclk_prev[i]) begin
            edges[i]++;
            bits[i] = {bits[i][14:0], mosi[i]};
            chk("mosi_setup_ok", i, int'(mosi_run[i] > hp), 1);
          end
        end else begin
          chk("idle_sclk", i, int'(sclk[i]), 0);
          chk("idle_mosi", i, int'(mosi[i]), 1);
          if (!ss_prev[i]) begin
            chk("sclk_edges", i, edges[i], 16);
            chk("ss_low_len", i, low_len[i], 33 * hp);
            chk("frame_expected", i, int'(exp_pending[i]), 1);
            if (exp_pending[i]) chk("frame", i, int'(bits[i]), int'(exp_frame[i]));
            exp_pending[i] = 0;
            last_frame[i]  = bits[i];
            high_len[i]    = 0;
          end
          high_len[i]++;
        end
        ss_prev[i] = ss[i]; sclk_prev[i] = sclk[i]; mosi_prev[i] = mosi[i];
      end
      // advance to the next cycle using the inputs the DUT samples on the coming edge
      if (rst) reset_model(i);
      else begin
        drop_pend[i] = 0; err_pend[i] = 0; acc[i] = 0;
        if (bcnt[i] > 0) bcnt[i]--;
        else if (vs) begin
          acc[i] = 1; g[i] = sel;
          if (a >= 4'd10) begin
            drop_pend[i] = 1; err_pend[i] = 1;
          end
`ifdef DISP_SCHED_SHADOW_EN
          else if (shv[i][a] && sh[i][a] == d) drop_pend[i] = 1;
`endif
          else begin
            bcnt[i] = 33 * hp + gp - 1;
            exp_frame[i] = {4'b0001, a, d};
            exp_pending[i] = 1;
`ifdef DISP_SCHED_SHADOW_EN
            sh[i][a] = d; shv[i][a] = 1;
`endif
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v0[i] = 0; v1[i] = 0; a0[i] = '0; a1[i] = '0; d0[i] = '0; d1[i] = '0;
    end
  endtask

  task automatic do_req(input int idx, input vec_t v);
    bit got_acc [2];
    bit seen [2];
    bit err_at [2];
    int n;
    for (int i = 0; i < 2; i++) begin
      got_acc[i] = 0; seen[i] = 0; err_at[i] = 0; last_frame[i] = '0;
      v0[i] = !v.port; v1[i] = v.port;
      a0[i] = v.addr; a1[i] = v.addr; d0[i] = v.data; d1[i] = v.data;
    end
    n = 0;
    while (!(seen[0] && seen[1]) && n < 400) begin
      tick();
      n++;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          got_acc[i] = 1; v0[i] = 0; v1[i] = 0;
        end else if (got_acc[i] && obs_done[i] && !seen[i]) begin
          seen[i] = 1; err_at[i] = obs_err[i];
        end
      end
    end
    chk("req_completed", idx, int'(seen[0] && seen[1]), 1);
    for (int i = 0; i < 2; i++) begin
      chk("req_err_flag", i, int'(err_at[i]), int'(v.exp_err));
      if (!v.exp_err) chk("req_frame", i, int'(last_frame[i]), int'(v.frame));
    end
    $display("req %0d: port=%0d addr=%0h data=%02h err=%0d frame=%04h", idx, v.port, v.addr,
             v.data, err_at[0], last_frame[0]);
  endtask

  function automatic logic [3:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    int n;
    int prev [2];
    vecs[0] = '{1'b0, 4'h1, 8'hA5, 1'b0, 16'h11A5};
    vecs[1] = '{1'b1, 4'hC, 8'h00, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 4'h9, 8'h3C, 1'b0, 16'h193C};
    vecs[3] = '{1'b0, 4'hA, 8'h55, 1'b1, 16'h0000};
    vecs[4] = '{1'b0, 4'h0, 8'h81, 1'b0, 16'h1081};
    vecs[5] = '{1'b1, 4'hF, 8'h81, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 4'h5, 8'h00, 1'b0, 16'h1500};

    rst = 1'b1;
    idle_inputs();
    reset_model(0);
    reset_model(1);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) do_req(k, vecs[k]);

    // reset in the middle of a frame, after the 7th SCLK rising edge of instance 0
    v0[0] = 1; a0[0] = 4'h6; d0[0] = 8'h77;
    n = 0;
    while (!(edges[0] == 7 && !ss_prev[0] && sclk_prev[0]) && n < 200) begin
      tick();
      n++;
      if (acc[0]) v0[0] = 0;
    end
    chk("reach_edge7", 0, int'(edges[0]), 7);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ss", 0, int'(ss[0]), 1);
    chk("rst_sclk", 0, int'(sclk[0]), 0);
    chk("rst_mosi", 0, int'(mosi[0]), 1);
    chk("rst_busy", 0, int'(busy[0]), 0);
    $display("reset mid-frame applied");
    do_req(7, '{1'b0, 4'h0, 8'hFF, 1'b0, 16'h10FF});

    // both ports held valid: grants must alternate
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1; a0[i] = 4'h2; d0[i] = 8'h11;
      v1[i] = 1; a1[i] = 4'h3; d1[i] = 8'h22;
      prev[i] = -1;
    end
    for (int k = 0; k < 320; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if (prev[i] >= 0) chk("alternate", i, int'(g[i]), 1 - prev[i]);
          prev[i] = int'(g[i]);
          $display("contend inst%0d: granted port %0d", i, g[i]);
        end
      end
    end

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        v0[i] = ($urandom_range(0, 3) == 0);
        v1[i] = ($urandom_range(0, 3) == 0);
        a0[i] = rand_addr();
        a1[i] = rand_addr();
        d0[i] = 8'($urandom_range(0, 3));
        d1[i] = 8'($urandom_range(0, 3));
      end
      tick();
    end

    idle_inputs();
    repeat (100) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
